alu_operand_ctrl: RTL

- Drives the 8-bit ALU and consumes its result, as a synchronous front end.
- Accepts an operation command, then collects operands A and B from the data bus over a valid/ready handshake and presents them stable to the ALU.
- Enables the ALU output transceiver for one cycle, then latches the result byte and the N/Z flags into registers for the rest of the CPU.
- Replaces ad-hoc microcode strobes around the ALU with a single sequenced transaction.

---
 rtl/alu_operand_ctrl_if.sv | 41 ++++
 rtl/alu_operand_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_operand_ctrl_if.sv
// ALU front-end bundle: command, operand bus handshake, ALU drive/result and status.
// slave  : seen from alu_operand_ctrl (consumes command/bus/ALU result, drives the rest).
// master : seen from the CPU/ALU side that drives the command, bus and ALU result.
interface alu_operand_ctrl_if;
  logic       i_start;
  logic [1:0] i_cmdOp;
  logic       i_cmdSub;
  logic       i_cmdShiftLeft;
  logic [7:0] i_bus;
  logic       i_busValid;
  logic       o_busReady;
  logic [7:0] o_a;
  logic [7:0] o_b;
  logic [1:0] o_aluOp;
  logic       o_sub;
  logic       o_shiftLeft;
  logic       o_aluOe;
  logic [7:0] i_y;
  logic       i_negative;
  logic       i_zero;
  logic [7:0] o_result;
  logic       o_flagN;
  logic       o_flagZ;
  logic       o_busy;
  logic       o_done;
  logic       o_error;

  modport slave (
    input  i_start, i_cmdOp, i_cmdSub, i_cmdShiftLeft, i_bus, i_busValid,
    input  i_y, i_negative, i_zero,
    output o_busReady, o_a, o_b, o_aluOp, o_sub, o_shiftLeft, o_aluOe,
    output o_result, o_flagN, o_flagZ, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_cmdOp, i_cmdSub, i_cmdShiftLeft, i_bus, i_busValid,
    output i_y, i_negative, i_zero,
    input  o_busReady, o_a, o_b, o_aluOp, o_sub, o_shiftLeft, o_aluOe,
    input  o_result, o_flagN, o_flagZ, o_busy, o_done, o_error
  );
endinterface

// File: rtl/alu_operand_ctrl.sv
// Sequenced front end for the 8-bit ALU: latches a command, collects operands A and B over a
// valid/ready bus handshake, enables the ALU output for one cycle, then latches result and N/Z.
// Ports:
//   i_clk, i_rst : clock (rising edge) and synchronous active-high reset
//   bus          : alu_operand_ctrl_if.slave -- command, operand bus, ALU drive/result, status
module alu_operand_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15  // legal 1..255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  alu_operand_ctrl_if.slave bus
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StSettle,
    StCapture,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       sub_q, sub_d;
  logic       shl_q, shl_d;
  logic [7:0] result_q, result_d;
  logic       flag_n_q, flag_n_d;
  logic       flag_z_q, flag_z_d;
  logic       error_q, error_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sub_d    = sub_q;
    shl_d    = shl_q;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          op_d    = bus.i_cmdOp;
          sub_d   = bus.i_cmdSub;
          shl_d   = bus.i_cmdShiftLeft;
          error_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = StLoadA;
        end
      end
      StLoadA, StLoadB: begin
        if (bus.i_busValid) begin
          if (state_q == StLoadA) begin
            a_d     = bus.i_bus;
            state_d = StLoadB;
          end else begin
            b_d     = bus.i_bus;
            state_d = StSettle;
          end
          // Timeout budget is per beat, so every accepted beat restarts it.
          cnt_d = 8'd0;
        end else begin
          cnt_d = (cnt_q >= TimeoutVal) ? TimeoutVal : cnt_q + 8'd1;
          if (cnt_d == TimeoutVal) begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StSettle: state_d = StCapture;
      StCapture: begin
        result_d = bus.i_y;
        flag_n_d = bus.i_negative;
        flag_z_d = bus.i_zero;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      op_q     <= 2'd0;
      sub_q    <= 1'b0;
      shl_q    <= 1'b0;
      result_q <= 8'd0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sub_q    <= sub_d;
      shl_q    <= shl_d;
      result_q <= result_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      error_q  <= error_d;
    end
  end

  // Handshake and strobes decode from state only: no input-to-output combinational path.
  assign bus.o_busReady  = (state_q == StLoadA) || (state_q == StLoadB);
  assign bus.o_aluOe     = (state_q == StCapture);
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_done      = (state_q == StDone);
  assign bus.o_a         = a_q;
  assign bus.o_b         = b_q;
  assign bus.o_aluOp     = op_q;
  assign bus.o_sub       = sub_q;
  assign bus.o_shiftLeft = shl_q;
  assign bus.o_result    = result_q;
  assign bus.o_flagN     = flag_n_q;
  assign bus.o_flagZ     = flag_z_q;
  assign bus.o_error     = error_q;

endmodule
